// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed hex display driver with frame-aligned word updates
// Digit scan is paced by scan_clk edges; new words only take effect at the frame wrap.
module seg7_scan_driver #(
  parameter int DIGITS         = 8,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_clk,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  input  logic                data_valid,
  output logic                data_ready,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                dp
);

  localparam int                IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  prev_q, prev_d;
  logic                  tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_data_q, pend_data_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_blank_q, pend_blank_d;
  logic [4*DIGITS-1:0]   disp_data_q, disp_data_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic                  disp_blank_q, disp_blank_d;
  logic                  data_ready_q, data_ready_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  boundary;
  logic [DIGITS-1:0]     blank_vec;
  logic [DIGITS-1:0]     onehot;
  logic [3:0]            nib;
  logic [6:0]            seg_lit;
  logic                  dp_lit;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Tick is registered so outputs move exactly four clk after the scan_clk rise.
  always_comb begin
    sync1_d  = scan_clk;
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    tick_d   = sync2_q & ~prev_q;
    boundary = tick_q & (idx_q == LAST_IDX);

    idx_d = idx_q;
    if (tick_q) begin
      idx_d = boundary ? '0 : idx_q + IDX_W'(1);
    end

    state_d      = state_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;

    // A capture coinciding with the wrap tick stays pending until the next wrap.
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          pend_data_d  = data_in;
          pend_dp_d    = dp_in;
          pend_blank_d = blank_lz;
          state_d      = ST_PEND;
        end
      end
      ST_PEND: begin
        if (boundary) begin
          disp_data_d  = pend_data_q;
          disp_dp_d    = pend_dp_q;
          disp_blank_d = pend_blank_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    data_ready_d = (state_d == ST_IDLE);
  end

  // Walk from the most significant digit; blank while every nibble so far is zero.
  always_comb begin
    logic lead_zero;
    lead_zero = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (disp_data_d[4*i +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
      blank_vec[i] = disp_blank_d & lead_zero & (i != 0);
    end
  end

  always_comb begin
    onehot  = DIGITS'(1) << idx_d;
    nib     = disp_data_d[{idx_d, 2'b00} +: 4];
    seg_lit = blank_vec[idx_d] ? 7'h00 : seg_decode(nib);
    dp_lit  = disp_dp_d[idx_d];

    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (tick_q) begin
      an_d  = AN_ACTIVE_LOW ? ~onehot : onehot;
      seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      tick_q       <= 1'b0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= 1'b0;
      data_ready_q <= 1'b1;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      data_ready_q <= data_ready_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign data_ready = data_ready_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized self-checking bench for seg7_scan_driver
// Display contents are predicted from committed words using arithmetic on the hex word.
module tb_seg7_scan_driver;

  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_clk = 1'b0;
  logic [31:0] data_in = '0;
  logic [7:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit scan_run = 1'b0;
  int ph       = 9;
  int rise_cyc = 0;

  int          m_idx = 0;
  logic [31:0] m_word = '0, p_word = '0;
  logic [7:0]  m_dp = '0, p_dp = '0;
  logic        m_blank = 1'b0, p_blank = 1'b0;
  bit          m_pend = 1'b0;
  int          cap_cyc = 0;
  int          last_chg = 0;
  int          dwell = 0;
  logic [7:0]  last_an = 8'hFF;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(.DIGITS(DIGITS), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_clk   (scan_clk),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Divide-by-10 scan clock: 5 clk high, 5 clk low.
  always begin
    @(posedge clk);
    #1;
    if (scan_run) begin
      ph = (ph + 1) % 10;
      scan_clk = (ph < 5);
      if (ph == 0) rise_cyc = cyc;
    end else begin
      ph = 9;
      scan_clk = 1'b0;
    end
  end

  function automatic logic [7:0] exp_an(int i);
    logic [7:0] one = 8'h01;
    return ~(one << i);
  endfunction

  function automatic logic [6:0] exp_seg(int i);
    logic [31:0] upper = m_word >> (4 * i);
    if (m_blank && i > 0 && upper == 0) return 7'h7F;
    return ~seg_tab[upper[3:0]];
  endfunction

  function automatic logic exp_dp(int i);
    logic [7:0] d = m_dp;
    return ~d[i];
  endfunction

  task automatic apply_reset();
    scan_run = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_idx = 0; m_word = '0; m_dp = '0; m_blank = 1'b0; m_pend = 1'b0;
    last_an = 8'hFF;
    last_chg = cyc;
    scan_run = 1'b1;
  endtask

  task automatic step(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (an !== last_an) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      last_an = an;
      dwell = cyc - last_chg;
      last_chg = cyc;
      m_idx = (m_idx + 1) % DIGITS;
      if (m_idx == 0 && m_pend && cap_cyc < cyc) begin
        m_word = p_word; m_dp = p_dp; m_blank = p_blank; m_pend = 1'b0;
      end
    end
  endtask

  task automatic offer(input logic [31:0] w, input logic [7:0] d, input logic b);
    @(negedge clk);
    data_in = w; dp_in = d; blank_lz = b; data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    if (!m_pend) begin
      m_pend = 1'b1; p_word = w; p_dp = d; p_blank = b; cap_cyc = cyc;
    end
    data_in = $urandom; dp_in = 8'($urandom); blank_lz = 1'($urandom);
  endtask

  task automatic run_to_frame_start(output bit ok);
    ok = 1'b1;
    for (int k = 0; k < 20 && ok && (m_pend || m_idx != 0); k++) step(ok);
    if (m_pend || m_idx != 0) ok = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    n_checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || data_ready !== 1'b1)
      $display("FAIL reset_state an=%h seg=%h dp=%b rdy=%b want FF/7F/1/1", an, seg, dp, data_ready);
    else n_pass++;
    step(ok);
    n_checks++;
    if (!ok || an !== 8'hFD)
      $display("FAIL first_tick ok=%b an=%h want FD", ok, an);
    else n_pass++;
    offer(32'h89AB_CDEF, 8'h0F, 1'b0);
    run_to_frame_start(ok);
    step(ok);
    offer(32'h1234_5678, 8'hF0, 1'b1);
    step(ok);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || data_ready !== 1'b1)
      $display("FAIL async_reset an=%h seg=%h dp=%b rdy=%b want FF/7F/1/1", an, seg, dp, data_ready);
    else n_pass++;
    apply_reset();
    for (int k = 0; k < DIGITS; k++) begin
      step(ok);
      n_checks++;
      if (!ok || an !== exp_an(m_idx) || seg !== 7'h40 || dp !== 1'b1 || data_ready !== 1'b1)
        $display("FAIL reset_discard idx=%0d an=%h/%h seg=%h/40 dp=%b rdy=%b", m_idx, an, exp_an(m_idx), seg, dp, data_ready);
      else n_pass++;
    end
  endtask

  task automatic test_tick_timing();
    bit ok;
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      step(ok);
      n_checks++;
      if (!ok || an !== exp_an(m_idx) || seg !== exp_seg(m_idx))
        $display("FAIL scan_order k=%0d an=%h want %h seg=%h want %h", k, an, exp_an(m_idx), seg, exp_seg(m_idx));
      else n_pass++;
      n_checks++;
      if (last_chg - rise_cyc != 4)
        $display("FAIL tick_latency k=%0d got %0d clk want 4", k, last_chg - rise_cyc);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (dwell != 10) $display("FAIL dwell k=%0d got %0d want 10", k, dwell);
        else n_pass++;
      end
    end
  endtask

  task automatic test_decode();
    bit ok;
    logic [6:0] want;
    offer(32'h0123_89AF, 8'h00, 1'b0);
    run_to_frame_start(ok);
    for (int k = 0; k < DIGITS; k++) begin
      if (k > 0) step(ok);
      want = (m_idx == 0) ? 7'h0E : (m_idx == 1) ? 7'h08 : (m_idx == 7) ? 7'h40 : exp_seg(m_idx);
      n_checks++;
      if (!ok || an !== exp_an(m_idx) || seg !== want || seg !== exp_seg(m_idx) || dp !== 1'b1)
        $display("FAIL decode idx=%0d an=%h seg=%h want %h dp=%b", m_idx, an, seg, want, dp);
      else n_pass++;
    end
  endtask

  task automatic test_blanking();
    bit ok;
    logic [6:0] want;
    offer(32'h0000_0A00, 8'h00, 1'b1);
    run_to_frame_start(ok);
    for (int k = 0; k < DIGITS; k++) begin
      if (k > 0) step(ok);
      want = (m_idx >= 3) ? 7'h7F : (m_idx == 2) ? 7'h08 : 7'h40;
      n_checks++;
      if (!ok || seg !== want) $display("FAIL blank_0A00 idx=%0d seg=%h want %h", m_idx, seg, want);
      else n_pass++;
    end
    step(ok);
    offer(32'h0000_0000, 8'h00, 1'b1);
    run_to_frame_start(ok);
    for (int k = 0; k < DIGITS; k++) begin
      if (k > 0) step(ok);
      want = (m_idx == 0) ? 7'h40 : 7'h7F;
      n_checks++;
      if (!ok || seg !== want) $display("FAIL blank_zero idx=%0d seg=%h want %h", m_idx, seg, want);
      else n_pass++;
    end
  endtask

  task automatic test_tear_free();
    bit ok;
    offer(32'h1111_1111, 8'h00, 1'b0);
    run_to_frame_start(ok);
    repeat (3) step(ok);
    offer(32'h2222_2222, 8'h00, 1'b0);
    offer(32'h3333_3333, 8'h00, 1'b0);
    @(negedge clk);
    n_checks++;
    if (data_ready !== 1'b0) $display("FAIL tear_ready_low got %b want 0", data_ready);
    else n_pass++;
    while (m_idx != 0) begin
      step(ok);
      if (!ok) break;
      n_checks++;
      if (m_idx != 0 && (seg !== 7'h79 || data_ready !== 1'b0))
        $display("FAIL tear_old_frame idx=%0d seg=%h want 79 rdy=%b want 0", m_idx, seg, data_ready);
      else if (m_idx == 0 && (seg !== 7'h24 || data_ready !== 1'b1))
        $display("FAIL tear_new_frame seg=%h want 24 rdy=%b want 1", seg, data_ready);
      else n_pass++;
    end
    for (int k = 1; k < DIGITS; k++) begin
      step(ok);
      n_checks++;
      if (!ok || seg !== 7'h24) $display("FAIL tear_second_ignored idx=%0d seg=%h want 24", m_idx, seg);
      else n_pass++;
    end
  endtask

  task automatic test_coincidence();
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 10 && ok && m_idx != DIGITS - 1; k++) step(ok);
    repeat (8) @(negedge clk);
    offer(32'h5555_5555, 8'h00, 1'b0);
    step(ok);
    n_checks++;
    if (!ok || m_idx != 0 || seg !== 7'h24 || data_ready !== 1'b0)
      $display("FAIL coincide_wrap idx=%0d seg=%h want 24 rdy=%b want 0", m_idx, seg, data_ready);
    else n_pass++;
    for (int k = 0; k < DIGITS; k++) begin
      step(ok);
      n_checks++;
      if (!ok || seg !== (m_idx == 0 ? 7'h12 : 7'h24))
        $display("FAIL coincide_frame idx=%0d seg=%h want %h", m_idx, seg, (m_idx == 0 ? 7'h12 : 7'h24));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] w;
    for (int it = 0; it < 8; it++) begin
      run_to_frame_start(ok);
      step(ok);
      w = $urandom;
      w = w >> (4 * $urandom_range(0, 7));
      offer(w, 8'($urandom), 1'($urandom_range(0, 1)));
      offer($urandom, 8'($urandom), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2 * DIGITS; k++) begin
        step(ok);
        n_checks++;
        if (!ok || an !== exp_an(m_idx) || seg !== exp_seg(m_idx) || dp !== exp_dp(m_idx) || data_ready !== logic'(!m_pend))
          $display("FAIL random it=%0d idx=%0d an=%h/%h seg=%h/%h dp=%b/%b rdy=%b/%b", it, m_idx,
                   an, exp_an(m_idx), seg, exp_seg(m_idx), dp, exp_dp(m_idx), data_ready, !m_pend);
        else n_pass++;
      end
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_tick_timing();
    test_decode();
    test_blanking();
    test_tear_free();
    test_coincidence();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
